multdiv_unit: RTL and testbench
===============================

Name: multdiv_unit

Overview:
- Multi-cycle signed 32-bit multiply/divide responder.
- Consumes the isMult / isDiv pulses and forwarded operands issued by the decode/execute stage.
- Returns a result, an exception flag and a one-cycle ready strobe; the pipeline stalls on `busy`.
- Sits beside the ALU in the execute stage; the result is written back through the normal X/M path once `data_resultRDY` fires.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported.
- ITER, 32, iterations per operation; sets latency to ITER+1.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > ITER.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high.
- ctrl_MULT  input  1  one-cycle start pulse for signed multiply (driven from isMult).
- ctrl_DIV  input  1  one-cycle start pulse for signed divide (driven from isDiv).
- data_operandA  input  WIDTH  multiplicand / dividend (forwarded rs).
- data_operandB  input  WIDTH  multiplier / divisor (forwarded rt).
- data_result  output  WIDTH  low 32 bits of the product, or the quotient.
- data_exception  output  1  overflow or divide-by-zero; valid only with `data_resultRDY`.
- data_resultRDY  output  1  one-cycle completion strobe.
- busy  output  1  operation in flight; the pipeline stalls while high.

Behaviour:
- Reset (synchronous, active-high): all of the following are cleared at the edge where reset=1, and reset overrides any ctrl pulse in the same cycle.
  - State goes to IDLE.
  - data_result=0, data_exception=0, data_resultRDY=0, busy=0, counter=0.
- States: IDLE, MUL, DIV, DONE.
- Start (edge E0), taken from any state:
  - ctrl_MULT=1 → MUL. ctrl_DIV=1 (with ctrl_MULT=0) → DIV. Both high → MULT wins.
  - Operands are latched at E0, counter cleared, busy=1 from E0.
- Restart mid-operation: a ctrl pulse while in MUL, DIV or DONE aborts the current operation.
  - The aborted operation produces no RDY strobe.
  - The new operation restarts from E0 with the new operands.
- MUL: radix-2 Booth multiply.
  - State: 64-bit product register {P_hi, P_lo=multiplier} plus a 1-bit Booth guard, guard=0 at E0.
  - Each edge E1..E32: on {P_lo[0], guard} = 01 add the multiplicand into P_hi; on 10 subtract it; otherwise no change. Then arithmetic-shift {P_hi, P_lo, guard} right by 1. Counter increments.
  - The add/subtract is 33-bit sign-extended so that the −2^31 multiplicand is handled.
- DIV: restoring division on magnitudes.
  - |A| and |B| are computed at E0. Quotient sign = A[31]^B[31] is latched at E0.
  - Each edge E1..E32 shifts {R, Q} left; if R ≥ |B|, then R −= |B| and Q[0]=1.
- At E32 (counter==ITER−1) → DONE.
- DONE, at edge E33:
  - data_result, data_exception and data_resultRDY=1 are registered, busy=0, state → IDLE.
  - RDY is high for exactly cycle E33–E34 and returns to 0 at E34 unless a new completion occurs.
  - data_result and data_exception hold their values until the next completion or reset.
  - Latency: RDY is high 33 cycles after the start edge.
- MUL result and exception:
  - result = product[31:0].
  - exception=1 iff product[63:31] is not all-equal, i.e. the product does not fit in signed 32 bits.
- DIV result and exception:
  - Quotient is truncated toward zero; it is negated in the DONE cycle if the latched sign is 1. The remainder is discarded.
  - B==0 → result 0, exception 1, with the full 33-cycle latency kept.
  - A=0x80000000, B=0xFFFFFFFF → result 0x80000000, exception 1.
- Operand changes after E0 are ignored.
- The counter never wraps: the FSM leaves MUL/DIV at ITER.

Decomposition:
- Shared package: state encoding, ITER/CNT_W constants, and ALU opcode constants (mult=5'b00110, div=5'b00111) used jointly with the decoder.
- One sub-module: reuse the existing adder_cla_32_bit (33-bit wrap with sign extension) as the single shared add/subtract datapath for Booth steps, restoring compare/subtract and final negation.
- FSM, counter and registers stay in multdiv_unit.

Test Plan:
- MULT 7 × 0xFFFFFFFD (−3) pulse at E0 → busy high E0–E33; single RDY in cycle 33; result 0xFFFFFFEB, exc 0.
- MULT 0x00010000 × 0x00010000 → result 0x00000000, exc 1; MULT 0x80000000 × 1 → 0x80000000, exc 0.
- DIV 0xFFFFFFEF (−17) / 5 → 0xFFFFFFFD (−3), exc 0; DIV 17 / 0xFFFFFFFB (−5) → 0xFFFFFFFD.
- DIV 42 / 0 → result 0, exc 1, RDY at cycle 33; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, exc 1.
- DIV 100/7 started, MULT 6 × 7 pulsed 10 cycles later → exactly one RDY, 33 cycles after the MULT pulse, result 42; no RDY for the divide.
- Reset asserted at cycle 20 of a MULT → busy=0, result=0 next edge, no RDY ever; ctrl_MULT and reset together → stays IDLE.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit and the decoder
// that issues its start pulses.
package multdiv_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_ITER  = 32;
  localparam int MD_CNT_W = 6;

  // Width of the shared add/subtract datapath: one guard bit above the operands.
  localparam int ADD_W = MD_WIDTH + 1;

  // ALU opcodes that the decoder turns into isMult / isDiv.
  localparam logic [4:0] ALU_MULT = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } md_state_t;

  // Magnitude of a two's-complement word; 0x80000000 maps to 2^31 (unsigned).
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

  // A 64-bit product fits in signed 32 bits when bits 63..31 are all equal.
  function automatic logic fits_signed32(input logic [63:0] p);
    return (&p[63:31]) | ~(|p[63:31]);
  endfunction

endpackage

// File: rtl/multdiv_unit_adder.sv
// 33-bit carry-lookahead adder (4-bit lookahead groups, rippled between groups);
// the single add/subtract path shared by Booth steps, division and negation.
module adder_cla_32_bit
  import multdiv_pkg::*;
(
  input  logic [ADD_W-1:0] a,
  input  logic [ADD_W-1:0] b,
  input  logic             cin,
  output logic [ADD_W-1:0] sum
);

  localparam int GROUPS = (ADD_W - 1) / 4;

  logic [ADD_W-2:0] g;
  logic [ADD_W-2:0] p;
  logic [ADD_W-2:0] c;
  logic [GROUPS:0]  gc;

  // NOTE: every variable written here gets a value before any conditional
  // logic, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    g     = a[ADD_W-2:0] & b[ADD_W-2:0];
    p     = a[ADD_W-2:0] ^ b[ADD_W-2:0];
    c     = '0;
    gc    = '0;
    gc[0] = cin;
    for (int k = 0; k < GROUPS; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
      gc[k+1]  = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
    sum[ADD_W-2:0] = p ^ c;
    // Top bit only needs its own sum; the carry out of the wrap is dropped.
    sum[ADD_W-1]   = a[ADD_W-1] ^ b[ADD_W-1] ^ gc[GROUPS];
  end

endmodule

// File: rtl/multdiv_unit.sv
// Multi-cycle signed 32-bit multiply (radix-2 Booth) / divide (restoring on
// magnitudes) responder; result, exception and a one-cycle ready strobe.
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int ITER  = MD_ITER,
  parameter int CNT_W = MD_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  md_state_t        state;
  logic [CNT_W-1:0] counter;

  // Product {p_hi, p_lo} during MUL; remainder/quotient {R, Q} during DIV.
  logic [WIDTH-1:0] p_hi;
  logic [WIDTH-1:0] p_lo;
  logic [WIDTH-1:0] opnd;
  logic             guard;
  logic             op_div;
  logic             q_neg;
  logic             div_zero;

  logic [WIDTH:0]   add_a;
  logic [WIDTH:0]   add_b;
  logic [WIDTH:0]   add_sum;
  logic             add_cin;

  logic             start;
  logic             last_step;
  logic             div_ge;
  logic [1:0]       booth;

  assign start     = ctrl_MULT | ctrl_DIV;
  assign last_step = (counter == CNT_W'(ITER - 1));
  assign booth     = {p_lo[0], guard};
  assign div_ge    = ~add_sum[WIDTH];

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    case (state)
      MUL: begin
        add_a = {p_hi[WIDTH-1], p_hi};
        case (booth)
          2'b01: add_b = {opnd[WIDTH-1], opnd};
          2'b10: begin
            add_b   = ~{opnd[WIDTH-1], opnd};
            add_cin = 1'b1;
          end
          default: ;
        endcase
      end
      DIV: begin
        // Trial subtract of |B| from the left-shifted remainder.
        add_a   = {p_hi, p_lo[WIDTH-1]};
        add_b   = ~{1'b0, opnd};
        add_cin = 1'b1;
      end
      DONE: begin
        add_b   = ~{1'b0, p_lo};
        add_cin = 1'b1;
      end
      default: ;
    endcase
  end

  adder_cla_32_bit u_adder (
    .a   (add_a),
    .b   (add_b),
    .cin (add_cin),
    .sum (add_sum)
  );

  // NOTE: datapath registers carry no reset; they are always loaded at the
  // start edge before being read, and the FSM masks them while idle.
  always_ff @(posedge clock) begin
    if (start) begin
      p_hi     <= '0;
      guard    <= 1'b0;
      op_div   <= ~ctrl_MULT;
      q_neg    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      div_zero <= (data_operandB == '0);
      if (ctrl_MULT) begin
        opnd <= data_operandA;
        p_lo <= data_operandB;
      end else begin
        opnd <= abs32(data_operandB);
        p_lo <= abs32(data_operandA);
      end
    end else begin
      case (state)
        MUL: begin
          p_hi  <= add_sum[WIDTH:1];
          p_lo  <= {add_sum[0], p_lo[WIDTH-1:1]};
          guard <= p_lo[0];
        end
        DIV: begin
          p_hi <= div_ge ? add_sum[WIDTH-1:0] : {p_hi[WIDTH-2:0], p_lo[WIDTH-1]};
          p_lo <= {p_lo[WIDTH-2:0], div_ge};
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      counter        <= '0;
      busy           <= 1'b0;
      data_resultRDY <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (start) begin
        // A new pulse aborts whatever was in flight, including a pending DONE.
        state   <= ctrl_MULT ? MUL : DIV;
        counter <= '0;
        busy    <= 1'b1;
      end else begin
        case (state)
          MUL, DIV: begin
            counter <= counter + CNT_W'(1);
            if (last_step) state <= DONE;
          end
          DONE: begin
            state          <= IDLE;
            busy           <= 1'b0;
            data_resultRDY <= 1'b1;
            if (op_div) begin
              data_result    <= div_zero ? '0 : (q_neg ? add_sum[WIDTH-1:0] : p_lo);
              // Only -2^31 / -1 yields a positive 2^31 quotient.
              data_exception <= div_zero | (~q_neg & p_lo[WIDTH-1]);
            end else begin
              data_result    <= p_lo;
              data_exception <= ~fits_signed32({p_hi, p_lo});
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: directed vector table, randomized ops
// against an arithmetic reference model, plus abort and reset sequences.
module tb_multdiv_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int passed = 0;
  int total  = 0;

  localparam longint S32_MAX = 64'sd2147483647;
  localparam longint S32_MIN = -64'sd2147483648;

  // mode: 0 = multiply, 1 = divide, 2 = both pulses (multiply expected)
  typedef struct {
    int          mode;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        exc;
  } vec_t;

  vec_t vecs[12];

  multdiv_unit dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic void model(input int mode, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output logic exc);
    longint sa, sb, r;
    sa = $signed(a);
    sb = $signed(b);
    if (mode != 1) begin
      r   = sa * sb;
      res = r[31:0];
      exc = (r > S32_MAX) || (r < S32_MIN);
    end else if (b == 32'd0) begin
      res = 32'd0;
      exc = 1'b1;
    end else begin
      r   = sa / sb;
      res = r[31:0];
      exc = (r > S32_MAX);
    end
  endfunction

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0: v = $urandom;
      1: v = $urandom_range(0, 300);
      2: case ($urandom_range(0, 4))
           0: v = 32'h0000_0000;
           1: v = 32'h0000_0001;
           2: v = 32'hFFFF_FFFF;
           3: v = 32'h8000_0000;
           default: v = 32'h7FFF_FFFF;
         endcase
      default: v = $urandom >> $urandom_range(0, 31);
    endcase
    if ($urandom_range(0, 1) == 1) v = ~v + 32'd1;
    return v;
  endfunction

  task automatic run_op(input int mode, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic exc, input string tag);
    int cyc;
    bit busy_ok;
    @(negedge clock);
    ctrl_MULT     = (mode != 1);
    ctrl_DIV      = (mode != 0);
    data_operandA = a;
    data_operandB = b;
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    busy_ok = busy;
    cyc     = 0;
    while (!data_resultRDY && cyc < 40) begin
      @(negedge clock);
      cyc++;
      if (!data_resultRDY && !busy) busy_ok = 1'b0;
    end
    check({tag, " busy_while_running"}, 64'(busy_ok), 64'd1);
    check({tag, " latency"}, 64'(cyc), 64'd33);
    check({tag, " result"}, 64'(data_result), 64'(res));
    check({tag, " exception"}, 64'(data_exception), 64'(exc));
    check({tag, " busy_at_rdy"}, 64'(busy), 64'd0);
    @(negedge clock);
    check({tag, " rdy_one_cycle"}, 64'(data_resultRDY), 64'd0);
    check({tag, " result_held"}, 64'(data_result), 64'(res));
  endtask

  initial begin
    int cyc;
    int cnt;
    int first;
    logic [31:0] first_res;
    logic [31:0] ra, rb, rres;
    logic        rexc;
    int          rmode;

    vecs[0]  = '{0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
    vecs[1]  = '{0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1};
    vecs[2]  = '{0, 32'h8000_0000, 32'd1,         32'h8000_0000, 1'b0};
    vecs[3]  = '{1, 32'hFFFF_FFEF, 32'd5,         32'hFFFF_FFFD, 1'b0};
    vecs[4]  = '{1, 32'd17,        32'hFFFF_FFFB, 32'hFFFF_FFFD, 1'b0};
    vecs[5]  = '{1, 32'd42,        32'd0,         32'h0000_0000, 1'b1};
    vecs[6]  = '{1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    vecs[7]  = '{2, 32'd6,         32'd3,         32'd18,        1'b0};
    vecs[8]  = '{0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1};
    vecs[9]  = '{0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0};
    vecs[10] = '{1, 32'h8000_0000, 32'd1,         32'h8000_0000, 1'b0};
    vecs[11] = '{1, 32'd0,         32'hFFFF_FFF9, 32'h0000_0000, 1'b0};

    reset         = 1'b1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (2) @(negedge clock);
    check("reset busy", 64'(busy), 64'd0);
    check("reset rdy", 64'(data_resultRDY), 64'd0);
    check("reset result", 64'(data_result), 64'd0);
    check("reset exception", 64'(data_exception), 64'd0);
    reset = 1'b0;

    foreach (vecs[i])
      run_op(vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].exc,
             $sformatf("vec%0d", i));

    for (int i = 0; i < 24; i++) begin
      rmode = $urandom_range(0, 1);
      ra    = pick_operand();
      rb    = pick_operand();
      model(rmode, ra, rb, rres, rexc);
      run_op(rmode, ra, rb, rres, rexc, $sformatf("rand%0d", i));
    end

    // Divide aborted by a multiply issued ten cycles later.
    @(negedge clock);
    ctrl_DIV      = 1'b1;
    data_operandA = 32'd100;
    data_operandB = 32'd7;
    @(negedge clock);
    ctrl_DIV = 1'b0;
    repeat (9) @(negedge clock);
    ctrl_MULT     = 1'b1;
    data_operandA = 32'd6;
    data_operandB = 32'd7;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    cnt       = 0;
    first     = -1;
    first_res = '0;
    for (int c = 0; c < 50; c++) begin
      if (data_resultRDY) begin
        cnt++;
        if (first < 0) begin
          first     = c;
          first_res = data_result;
        end
      end
      @(negedge clock);
    end
    check("abort rdy_count", 64'(cnt), 64'd1);
    check("abort latency", 64'(first), 64'd33);
    check("abort result", 64'(first_res), 64'd42);

    // Reset in cycle 20 of a multiply.
    @(negedge clock);
    ctrl_MULT     = 1'b1;
    data_operandA = 32'd5;
    data_operandB = 32'd9;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    repeat (19) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset result", 64'(data_result), 64'd0);
    check("midreset exception", 64'(data_exception), 64'd0);
    check("midreset rdy", 64'(data_resultRDY), 64'd0);
    reset = 1'b0;
    cnt   = 0;
    for (int c = 0; c < 45; c++) begin
      @(negedge clock);
      if (data_resultRDY || busy) cnt++;
    end
    check("midreset no_activity", 64'(cnt), 64'd0);

    // Reset and a start pulse in the same cycle: reset wins.
    @(negedge clock);
    reset         = 1'b1;
    ctrl_MULT     = 1'b1;
    data_operandA = 32'd3;
    data_operandB = 32'd4;
    @(negedge clock);
    check("reset_and_start busy", 64'(busy), 64'd0);
    reset     = 1'b0;
    ctrl_MULT = 1'b0;
    cnt       = 0;
    for (int c = 0; c < 45; c++) begin
      @(negedge clock);
      if (data_resultRDY || busy) cnt++;
    end
    check("reset_and_start no_activity", 64'(cnt), 64'd0);
    check("reset_and_start result", 64'(data_result), 64'd0);

    // Normal operation resumes after the reset sequences.
    run_op(1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 1'b0, "post_reset");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
